conv2d_nav: RTL and testbench
=============================

CONV2D_NAV -- requirements
Module: conv2d_nav

Interface
- REQ-001 Parameters SHALL be as follows:
  - IN_CHANNELS, default 1, number of input feature channels.
  - OUT_CHANNELS, default 1, number of output channels.
  - KERN_SIZE, default 3, square kernel edge.
  - STRIDE, default 1, stride in both dimensions.
  - PADDING, default 0, zero-padding width on every edge.
  - IN_SIZE, default 5, square input edge.
  - DATA_SIZE, default 8, element width (signed two's complement).
  - DEB_CYCLES, default 16, debounce stable-count length.
  - TICK_DIV, default 1666666, clock cycles per display tick (60 Hz at 100 MHz).
- REQ-002 Derived constant OUT_SIZE SHALL equal (IN_SIZE + 2*PADDING - KERN_SIZE)/STRIDE + 1.
- REQ-003 Ports SHALL be as follows:
  - clk, input, 1, sole clock.
  - reset, input, 1, synchronous active-high reset.
  - in_data, input, IN_CHANNELS*IN_SIZE*IN_SIZE*DATA_SIZE, input tensor flattened in [c][row][col] order, element 0 in the LSBs.
  - kern_we, input, 1, kernel write strobe.
  - kern_addr, input, clog2(OUT_CHANNELS*IN_CHANNELS*KERN_SIZE^2), kernel flat index in [oc][ic][kr][kc] order.
  - kern_wdata, input, DATA_SIZE, kernel element value.
  - btn_next, input, 1, raw bouncing button that advances the selection.
  - btn_prev, input, 1, raw bouncing button that retreats the selection.
  - out_data, output, OUT_CHANNELS*OUT_SIZE*OUT_SIZE*DATA_SIZE, output tensor flattened in [oc][row][col] order.
  - sel_value, output, DATA_SIZE, output element at the current selection.
  - sel_index, output, clog2(OUT_CHANNELS*OUT_SIZE^2), flat index of the current selection.
  - disp_tick, output, 1, one-cycle pulse every TICK_DIV cycles.
- REQ-004 The design SHALL use one clock (clk); reset SHALL be synchronous and active-high.

Function
- REQ-005 out[oc][r][c] SHALL equal the sum over ic, kr, kc of in[ic][r*STRIDE+kr-PADDING][c*STRIDE+kc-PADDING] * kern[oc][ic][kr][kc].
- REQ-006 Any input coordinate outside 0..IN_SIZE-1 SHALL contribute 0.
- REQ-007 Products and sums SHALL be signed, accumulated at full width (2*DATA_SIZE + clog2(IN_CHANNELS*KERN_SIZE^2) bits) with no intermediate overflow.
- REQ-008 The final sum SHALL saturate to the signed DATA_SIZE range; with DATA_SIZE=8 the range is -128..127.
- REQ-009 out_data SHALL be registered and SHALL reflect in_data and the kernel memory as sampled on the previous rising edge, giving 1-cycle latency.
- REQ-010 A kernel write SHALL take effect on the edge where kern_we=1; kern_addr beyond range SHALL be ignored.
- REQ-011 Each raw button SHALL pass through a 2-flop synchronizer; a new level SHALL be accepted only after DEB_CYCLES consecutive identical samples.
- REQ-012 Each accepted 0->1 transition of a debounced button SHALL produce exactly one 1-cycle pulse; holding the button SHALL NOT repeat.
- REQ-013 A next pulse SHALL increment sel_index by 1 and SHALL saturate at OUT_CHANNELS*OUT_SIZE^2-1 with no wrap.
- REQ-014 A prev pulse SHALL decrement sel_index by 1 and SHALL saturate at 0.
- REQ-015 Simultaneous next and prev pulses SHALL leave sel_index unchanged.
- REQ-016 sel_value SHALL be combinational from out_data[sel_index].
- REQ-017 disp_tick SHALL be driven by a counter 0..TICK_DIV-1 and SHALL pulse when the counter wraps to 0.

Reset
- REQ-018 While reset=1, on the clock edge, sel_index, the tick counter, debounce counters, debounced levels and out_data SHALL all go to 0.
- REQ-019 disp_tick SHALL be 0 during reset.
- REQ-020 The kernel memory SHALL NOT be cleared by reset.
- REQ-021 A kern_we asserted during reset SHALL still write.
- REQ-022 Button activity during reset SHALL produce no pulses; a button held through reset release SHALL NOT produce a pulse until it is released and pressed again.

Structure
- REQ-023 Package conv2d_pkg SHALL hold DATA_SIZE default, the OUT_SIZE function and the saturation function.
- REQ-024 Sub-module debounce SHALL be instantiated twice, once per button, each with ports clk, reset, raw, pulse.
- REQ-025 The tick divider and convolution datapath SHALL be inline.

Verification (IN_CHANNELS=1, OUT_CHANNELS=1, IN_SIZE=3, DATA_SIZE=8 unless stated)
- REQ-026 KERN_SIZE=2, PADDING=0, inputs 1..9, kernel all 1 -> one cycle later out = 12, 16, 24, 28.
- REQ-027 KERN_SIZE=3, PADDING=1, inputs 1..9, kernel all 1 -> out[0][0]=12 and out[1][1]=45.
- REQ-028 KERN_SIZE=2, all inputs 127, kernel all 127 -> every out = 127; with kernel all -127 -> every out = -128.
- REQ-029 DEB_CYCLES=4, next bounced 3 times shorter than 4 cycles then held for 20 cycles -> exactly one pulse, sel_index 0->1.
- REQ-030 Navigation with 4 outputs: 5 next presses -> sel_index 3; then 5 prev presses -> 0; simultaneous press -> unchanged.
- REQ-031 TICK_DIV=10 -> disp_tick high once every 10 cycles; reset mid-count -> next tick exactly 10 cycles after reset release.

Source files
------------

// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared constants, types and helpers for the conv2d_nav block.
//   DATA_SIZE_DEF : default element width
//   db_state_e    : debounce arming state
//   out_size()    : output edge length for a given convolution geometry
//   saturate()    : clamp a wide signed value into a signed width-bit range
package conv2d_pkg;

   localparam int unsigned DATA_SIZE_DEF = 8;
   localparam int unsigned SAT_W         = 64;

   typedef enum logic {
      DB_WAIT_IDLE,
      DB_ARMED
   } db_state_e;

   function automatic int unsigned out_size(input int unsigned in_size,
                                            input int unsigned kern,
                                            input int unsigned stride,
                                            input int unsigned padding);
      return (in_size + 2 * padding - kern) / stride + 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned          width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/conv2d_nav_debounce.sv
// debounce: 2-flop synchronizer, stable-count debouncer and rising-edge pulser.
//   clk   : clock
//   reset : synchronous active-high reset
//   raw   : raw bouncing button level
//   pulse : one-cycle pulse per accepted press
module debounce
   import conv2d_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_level;
   logic            r_pulse;
   logic [CW-1:0]   r_cnt;
   db_state_e       r_state;

   // After reset the button must be seen released for DEB_CYCLES samples
   // before presses are honoured, so a press held through reset is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_state <= DB_WAIT_IDLE;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         case (r_state)
            DB_WAIT_IDLE: begin
               if (r_sync2) begin
                  r_cnt <= '0;
               end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_state <= DB_ARMED;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DB_ARMED: begin
               if (r_sync2 == r_level) begin
                  r_cnt <= '0;
               end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_level <= r_sync2;
                  r_pulse <= r_sync2;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= DB_WAIT_IDLE;
         endcase
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/conv2d_nav.sv
// conv2d_nav: registered 2-D convolution with saturating output, a button
// driven selector over the output tensor, and a display tick divider.
//   clk, reset        : clock, synchronous active-high reset
//   in_data           : input tensor [c][row][col], element 0 in LSBs
//   kern_we/addr/wdata: kernel memory write port, [oc][ic][kr][kc] order
//   btn_next/btn_prev : raw navigation buttons
//   out_data          : output tensor [oc][row][col], 1-cycle latency
//   sel_value         : element of out_data at sel_index
//   sel_index         : current flat selection
//   disp_tick         : one-cycle pulse every TICK_DIV cycles
module conv2d_nav
   import conv2d_pkg::*;
#(
   parameter int unsigned IN_CHANNELS  = 1,
   parameter int unsigned OUT_CHANNELS = 1,
   parameter int unsigned KERN_SIZE    = 3,
   parameter int unsigned STRIDE       = 1,
   parameter int unsigned PADDING      = 0,
   parameter int unsigned IN_SIZE      = 5,
   parameter int unsigned DATA_SIZE    = DATA_SIZE_DEF,
   parameter int unsigned DEB_CYCLES   = 16,
   parameter int unsigned TICK_DIV     = 1666666,
   localparam int unsigned OUT_SIZE = out_size(IN_SIZE, KERN_SIZE, STRIDE, PADDING),
   localparam int unsigned NK       = OUT_CHANNELS * IN_CHANNELS * KERN_SIZE * KERN_SIZE,
   localparam int unsigned NO       = OUT_CHANNELS * OUT_SIZE * OUT_SIZE,
   localparam int unsigned KA_W     = (NK > 1) ? $clog2(NK) : 1,
   localparam int unsigned SI_W     = (NO > 1) ? $clog2(NO) : 1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [IN_CHANNELS*IN_SIZE*IN_SIZE*DATA_SIZE-1:0] in_data,
   input  logic                                         kern_we,
   input  logic [KA_W-1:0]                              kern_addr,
   input  logic [DATA_SIZE-1:0]                         kern_wdata,
   input  logic                                         btn_next,
   input  logic                                         btn_prev,
   output logic [NO*DATA_SIZE-1:0]                      out_data,
   output logic [DATA_SIZE-1:0]                         sel_value,
   output logic [SI_W-1:0]                              sel_index,
   output logic                                         disp_tick
);

   localparam int unsigned NMAC  = IN_CHANNELS * KERN_SIZE * KERN_SIZE;
   localparam int unsigned ACC_W = 2 * DATA_SIZE + ((NMAC > 1) ? $clog2(NMAC) : 0);
   localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef logic signed [ACC_W-1:0] acc_t;

   logic signed [DATA_SIZE-1:0] r_kern [NK];
   logic [NO*DATA_SIZE-1:0]     r_out;
   logic [SI_W-1:0]             r_sel;
   logic [TW-1:0]               r_tick_cnt;
   logic                        r_tick;

   logic [NO*DATA_SIZE-1:0]     w_out;
   acc_t                        w_acc;
   logic signed [DATA_SIZE-1:0] w_x;
   int                          w_row;
   int                          w_col;
   logic                        w_next;
   logic                        w_prev;

   // Kernel memory has no reset and accepts writes even while reset is high.
   always_ff @(posedge clk) begin
      if (kern_we && ({1'b0, kern_addr} < (KA_W + 1)'(NK)))
         r_kern[kern_addr] <= kern_wdata;
   end

   always_comb begin
      w_out = '0;
      w_acc = '0;
      w_x   = '0;
      w_row = 0;
      w_col = 0;
      for (int unsigned oc = 0; oc < OUT_CHANNELS; oc++) begin
         for (int unsigned r = 0; r < OUT_SIZE; r++) begin
            for (int unsigned c = 0; c < OUT_SIZE; c++) begin
               w_acc = '0;
               for (int unsigned ic = 0; ic < IN_CHANNELS; ic++) begin
                  for (int unsigned kr = 0; kr < KERN_SIZE; kr++) begin
                     for (int unsigned kc = 0; kc < KERN_SIZE; kc++) begin
                        w_row = int'(r * STRIDE + kr) - int'(PADDING);
                        w_col = int'(c * STRIDE + kc) - int'(PADDING);
                        // Padding taps fall outside the input and add nothing.
                        if (w_row >= 0 && w_row < int'(IN_SIZE) &&
                            w_col >= 0 && w_col < int'(IN_SIZE)) begin
                           w_x = in_data[((ic * IN_SIZE + unsigned'(w_row)) * IN_SIZE
                                          + unsigned'(w_col)) * DATA_SIZE +: DATA_SIZE];
                           w_acc = w_acc + acc_t'(w_x) *
                                   acc_t'(r_kern[((oc * IN_CHANNELS + ic) * KERN_SIZE + kr)
                                                 * KERN_SIZE + kc]);
                        end
                     end
                  end
               end
               w_out[((oc * OUT_SIZE + r) * OUT_SIZE + c) * DATA_SIZE +: DATA_SIZE] =
                  DATA_SIZE'(saturate(SAT_W'(w_acc), DATA_SIZE));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_out <= '0;
      else       r_out <= w_out;
   end

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_next),
      .pulse (w_next)
   );

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_prev),
      .pulse (w_prev)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_sel <= '0;
      else if (w_next && !w_prev && r_sel != SI_W'(NO - 1))
         r_sel <= r_sel + 1'b1;
      else if (w_prev && !w_next && r_sel != '0)
         r_sel <= r_sel - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b1;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
         r_tick     <= 1'b0;
      end
   end

   assign out_data  = r_out;
   assign sel_index = r_sel;
   assign sel_value = r_out[r_sel * DATA_SIZE +: DATA_SIZE];
   assign disp_tick = r_tick;

endmodule

// File: tb/tb_conv2d_nav.sv
module tb_conv2d_nav;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // dut_a: 1x1 ch, K2 S1 P0, 3x3 in -> 2x2 out
   logic [71:0]  in_a;
   logic         we_a;
   logic [1:0]   addr_a;
   logic [7:0]   wd_a;
   logic         bn_a, bp_a;
   logic [31:0]  out_a;
   logic [7:0]   sv_a;
   logic [1:0]   si_a;
   logic         tk_a;
   // dut_b: 1->2 ch, K3 S1 P1, 3x3 in -> 3x3 out
   logic [71:0]  in_b;
   logic         we_b;
   logic [4:0]   addr_b;
   logic [7:0]   wd_b;
   logic [143:0] out_b;
   logic [7:0]   sv_b;
   logic [4:0]   si_b;
   logic         tk_b;
   // dut_c: 2->2 ch, K3 S2 P1, 5x5 in -> 3x3 out
   logic [399:0] in_c;
   logic         we_c;
   logic [5:0]   addr_c;
   logic [7:0]   wd_c;
   logic [143:0] out_c;
   logic [7:0]   sv_c;
   logic [4:0]   si_c;
   logic         tk_c;
   logic         zero = 1'b0;

   conv2d_nav #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .KERN_SIZE(2), .STRIDE(1), .PADDING(0),
                .IN_SIZE(3), .DATA_SIZE(8), .DEB_CYCLES(4), .TICK_DIV(10)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_a), .kern_we(we_a), .kern_addr(addr_a),
      .kern_wdata(wd_a), .btn_next(bn_a), .btn_prev(bp_a), .out_data(out_a),
      .sel_value(sv_a), .sel_index(si_a), .disp_tick(tk_a));

   conv2d_nav #(.IN_CHANNELS(1), .OUT_CHANNELS(2), .KERN_SIZE(3), .STRIDE(1), .PADDING(1),
                .IN_SIZE(3), .DATA_SIZE(8), .DEB_CYCLES(4), .TICK_DIV(10)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_b), .kern_we(we_b), .kern_addr(addr_b),
      .kern_wdata(wd_b), .btn_next(zero), .btn_prev(zero), .out_data(out_b),
      .sel_value(sv_b), .sel_index(si_b), .disp_tick(tk_b));

   conv2d_nav #(.IN_CHANNELS(2), .OUT_CHANNELS(2), .KERN_SIZE(3), .STRIDE(2), .PADDING(1),
                .IN_SIZE(5), .DATA_SIZE(8), .DEB_CYCLES(4), .TICK_DIV(10)) dut_c (
      .clk(clk), .reset(reset), .in_data(in_c), .kern_we(we_c), .kern_addr(addr_c),
      .kern_wdata(wd_c), .btn_next(zero), .btn_prev(zero), .out_data(out_c),
      .sel_value(sv_c), .sel_index(si_c), .disp_tick(tk_c));

   int n_cmp = 0;
   int n_err = 0;
   int ma_in[64], ma_k[64], mb_in[64], mb_k[64], mc_in[64], mc_k[64];
   int sel_m;

   task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Direct reading of the convolution definition, clamped to int8.
   function automatic int ref_out(input int inv[64], input int kv[64], input int icn,
                                  input int ks, input int st, input int pd, input int isz,
                                  input int oc, input int r, input int c);
      int s = 0;
      for (int ic = 0; ic < icn; ic++)
         for (int kr = 0; kr < ks; kr++)
            for (int kc = 0; kc < ks; kc++) begin
               int y = r * st + kr - pd;
               int x = c * st + kc - pd;
               if (y >= 0 && y < isz && x >= 0 && x < isz)
                  s += inv[(ic * isz + y) * isz + x] * kv[((oc * icn + ic) * ks + kr) * ks + kc];
            end
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   function automatic int rnd(input bit narrow);
      if (narrow) return int'($urandom_range(15)) - 8;
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < 9; i++)  in_a[i*8 +: 8] = 8'(ma_in[i]);
      for (int i = 0; i < 9; i++)  in_b[i*8 +: 8] = 8'(mb_in[i]);
      for (int i = 0; i < 50; i++) in_c[i*8 +: 8] = 8'(mc_in[i]);
   endtask

   task automatic load_a();
      for (int i = 0; i < 4; i++) begin
         we_a = 1'b1; addr_a = 2'(i); wd_a = 8'(ma_k[i]); tick();
      end
      we_a = 1'b0;
   endtask

   task automatic load_b();
      for (int i = 0; i < 18; i++) begin
         we_b = 1'b1; addr_b = 5'(i); wd_b = 8'(mb_k[i]); tick();
      end
      we_b = 1'b0;
   endtask

   task automatic load_c();
      for (int i = 0; i < 36; i++) begin
         we_c = 1'b1; addr_c = 6'(i); wd_c = 8'(mc_k[i]); tick();
      end
      we_c = 1'b0;
   endtask

   task automatic check_a(input string tag);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_a%0d", tag, i), $signed(out_a[i*8 +: 8]),
               ref_out(ma_in, ma_k, 1, 2, 1, 0, 3, 0, i / 2, i % 2));
   endtask

   task automatic check_b(input string tag);
      for (int i = 0; i < 18; i++)
         check($sformatf("%s_b%0d", tag, i), $signed(out_b[i*8 +: 8]),
               ref_out(mb_in, mb_k, 1, 3, 1, 1, 3, i / 9, (i % 9) / 3, i % 3));
   endtask

   task automatic check_c(input string tag);
      for (int i = 0; i < 18; i++)
         check($sformatf("%s_c%0d", tag, i), $signed(out_c[i*8 +: 8]),
               ref_out(mc_in, mc_k, 2, 3, 2, 1, 5, i / 9, (i % 9) / 3, i % 3));
   endtask

   task automatic press(input logic n, input logic p);
      bn_a = n; bp_a = p;
      repeat (12) tick();
      bn_a = 1'b0; bp_a = 1'b0;
      repeat (12) tick();
      if (n && !p && sel_m < 3) sel_m++;
      if (p && !n && sel_m > 0) sel_m--;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      in_a = '0; in_b = '0; in_c = '0;
      we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
      addr_a = '0; addr_b = '0; addr_c = '0;
      wd_a = '0; wd_b = '0; wd_c = '0;
      bn_a = 1'b0; bp_a = 1'b0;
      sel_m = 0;
      repeat (3) tick();
      check("rst_out_a", $signed(out_a), 0);
      check("rst_out_b0", $signed(out_b[31:0]), 0);
      check("rst_sel", {30'd0, si_a}, 0);
      check("rst_tick", {31'd0, tk_a}, 0);
      reset = 1'b0;

      // 3x3 ramp, all-ones 2x2 kernel
      for (int i = 0; i < 9; i++) ma_in[i] = i + 1;
      for (int i = 0; i < 4; i++) ma_k[i] = 1;
      load_a();
      drive_inputs();
      tick();
      check("ramp_00", $signed(out_a[7:0]),   12);
      check("ramp_01", $signed(out_a[15:8]),  16);
      check("ramp_10", $signed(out_a[23:16]), 24);
      check("ramp_11", $signed(out_a[31:24]), 28);

      // one-cycle latency: new inputs are not visible before the next edge
      for (int i = 0; i < 9; i++) ma_in[i] = 127;
      drive_inputs();
      #2;
      check("latency_hold", $signed(out_a[7:0]), 12);
      for (int i = 0; i < 4; i++) ma_k[i] = 127;
      load_a();
      tick();
      check_a("sat_hi");
      check("sat_hi_lit", $signed(out_a[15:8]), 127);
      for (int i = 0; i < 4; i++) ma_k[i] = -127;
      load_a();
      tick();
      check("sat_lo_lit", $signed(out_a[31:24]), -128);

      // padded 3x3 ramp on dut_b, second output channel negated
      for (int i = 0; i < 9; i++) mb_in[i] = i + 1;
      for (int i = 0; i < 18; i++) mb_k[i] = (i < 9) ? 1 : -1;
      load_b();
      drive_inputs();
      tick();
      check("pad_00", $signed(out_b[7:0]), 12);
      check("pad_11", $signed(out_b[39:32]), 45);
      check("pad_neg11", $signed(out_b[111:104]), -45);
      check_b("pad");

      // out-of-range kernel address is ignored
      we_b = 1'b1; addr_b = 5'd25; wd_b = 8'd99; tick();
      we_b = 1'b0; tick();
      check_b("oob");

      // randomized tensors, alternating narrow and full-range values
      for (int it = 0; it < 6; it++) begin
         bit nar = (it % 2) == 0;
         for (int i = 0; i < 9; i++)  ma_in[i] = rnd(nar);
         for (int i = 0; i < 4; i++)  ma_k[i]  = rnd(nar);
         for (int i = 0; i < 9; i++)  mb_in[i] = rnd(nar);
         for (int i = 0; i < 18; i++) mb_k[i]  = rnd(nar);
         for (int i = 0; i < 50; i++) mc_in[i] = rnd(nar);
         for (int i = 0; i < 36; i++) mc_k[i]  = rnd(nar);
         load_a(); load_b(); load_c();
         drive_inputs();
         tick();
         check_a("rnd"); check_b("rnd"); check_c("rnd");
      end

      // display tick period and restart after reset
      n = 0;
      while (!tk_a && n < 30) begin tick(); n++; end
      check("tick_seen", {31'd0, tk_a}, 1);
      n = 0;
      do begin tick(); n++; end while (!tk_a && n < 30);
      check("tick_period", n, 10);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("tick_in_rst", {31'd0, tk_a}, 0);
      tick();
      reset = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!tk_a && n < 30);
      check("tick_after_rst", n, 10);

      // kernel survives reset and writes during reset land
      reset = 1'b1;
      for (int i = 0; i < 4; i++) ma_k[i] = 2;
      load_a();
      check("rst_out_zero", $signed(out_a), 0);
      reset = 1'b0;
      tick();
      check_a("rstwr");
      check_b("keep");

      // bouncing next button: three short glitches then a solid hold
      repeat (10) tick();
      for (int b = 0; b < 3; b++) begin
         bn_a = 1'b1; repeat (2) tick();
         bn_a = 1'b0; repeat (2) tick();
      end
      bn_a = 1'b1; repeat (20) tick();
      check("bounce_sel", {30'd0, si_a}, 1);
      bn_a = 1'b0; repeat (12) tick();
      check("bounce_hold", {30'd0, si_a}, 1);
      sel_m = 1;
      check("sel_value1", $signed(sv_a), ref_out(ma_in, ma_k, 1, 2, 1, 0, 3, 0, 0, 1));

      // navigation with saturation at both ends
      for (int i = 0; i < 5; i++) begin
         press(1'b1, 1'b0);
         check($sformatf("next%0d", i), {30'd0, si_a}, sel_m);
      end
      check("next_sat", {30'd0, si_a}, 3);
      check("sel_value3", $signed(sv_a), ref_out(ma_in, ma_k, 1, 2, 1, 0, 3, 0, 1, 1));
      for (int i = 0; i < 5; i++) begin
         press(1'b0, 1'b1);
         check($sformatf("prev%0d", i), {30'd0, si_a}, sel_m);
      end
      check("prev_sat", {30'd0, si_a}, 0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      check("simul", {30'd0, si_a}, 1);

      // button held through reset release must not step the selection
      bn_a = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (20) tick();
      check("held_rst", {30'd0, si_a}, 0);
      bn_a = 1'b0;
      repeat (12) tick();
      check("held_release", {30'd0, si_a}, 0);
      sel_m = 0;
      press(1'b1, 1'b0);
      check("repress", {30'd0, si_a}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
